// File: rtl/float_copro_pkg.sv
// Shared types and constants for the float coprocessor controller.
package float_copro_pkg;

  localparam int OPC_W  = 11;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result returned for a divide by zero.
  localparam logic [DATA_W-1:0] DIV0_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/float_copro_ctrl.sv
// Sequencer between the LM32 user-instruction port and the combinational
// coprocessor datapath. One request at a time: operands are registered onto
// the datapath, held for a per-opcode multicycle window, and the result is
// returned with a single-cycle complete pulse. Illegal opcodes and divide by
// zero are trapped without touching the datapath registers.
module float_copro_ctrl
  import float_copro_pkg::*;
#(
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              user_valid_i,
  input  logic [OPC_W-1:0]  user_opcode_i,
  input  logic [DATA_W-1:0] user_operand_0_i,
  input  logic [DATA_W-1:0] user_operand_1_i,
  output logic [DATA_W-1:0] user_result_o,
  output logic              user_complete_o,
  output logic [OPC_W-1:0]  dp_opcode_o,
  output logic [DATA_W-1:0] dp_op0_o,
  output logic [DATA_W-1:0] dp_op1_o,
  input  logic [DATA_W-1:0] dp_result_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       ops_done_o
);

  localparam int LAT_MAX = (LAT_ADD > LAT_MUL) ?
                           ((LAT_ADD > LAT_DIV) ? LAT_ADD : LAT_DIV) :
                           ((LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV);
  localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OPC_W-1:0]    dp_opc_q, dp_opc_d;
  logic [DATA_W-1:0]   dp_op0_q, dp_op0_d;
  logic [DATA_W-1:0]   dp_op1_q, dp_op1_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic [31:0]         ops_q, ops_d;

  // Countdown load value: the datapath is given LAT cycles, EXEC exits on cnt==0.
  function automatic logic [CNT_W-1:0] lat_load(input logic [1:0] op);
    case (op_e'(op))
      OP_MUL:  lat_load = CNT_W'(LAT_MUL - 1);
      OP_DIV:  lat_load = CNT_W'(LAT_DIV - 1);
      default: lat_load = CNT_W'(LAT_ADD - 1);
    endcase
  endfunction

  // Next-state and next-register logic; every register holds unless updated.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dp_opc_d = dp_opc_q;
    dp_op0_d = dp_op0_q;
    dp_op1_d = dp_op1_q;
    res_d    = res_q;
    err_d    = err_q;
    ops_d    = ops_q;
    case (state_q)
      IDLE: begin
        if (user_valid_i) begin
          if (user_opcode_i > OPC_W'(3)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else if ((user_opcode_i == OPC_W'(3)) && (user_operand_1_i == '0)) begin
            res_d   = DIV0_RESULT;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            dp_opc_d = user_opcode_i;
            dp_op0_d = user_operand_0_i;
            dp_op1_d = user_operand_1_i;
            cnt_d    = lat_load(user_opcode_i[1:0]);
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = dp_result_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ops_d   = ops_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Counter, datapath operand, result and statistics registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      dp_opc_q <= '0;
      dp_op0_q <= '0;
      dp_op1_q <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      ops_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      dp_opc_q <= dp_opc_d;
      dp_op0_q <= dp_op0_d;
      dp_op1_q <= dp_op1_d;
      res_q    <= res_d;
      err_q    <= err_d;
      ops_q    <= ops_d;
    end
  end

  assign user_complete_o = (state_q == DONE);
  assign user_result_o   = user_complete_o ? res_q : '0;
  assign err_o           = user_complete_o ? err_q : 1'b0;
  assign busy_o          = (state_q == EXEC) || (state_q == DONE);
  assign dp_opcode_o     = dp_opc_q;
  assign dp_op0_o        = dp_op0_q;
  assign dp_op1_o        = dp_op1_q;
  assign ops_done_o      = ops_q;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Self-checking bench for float_copro_ctrl with a behavioural stand-in for
// the combinational datapath and a scoreboard of expected completions.
module tb_float_copro_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        user_valid;
  logic [10:0] user_opcode;
  logic [31:0] user_op0, user_op1;
  logic [31:0] user_result;
  logic        user_complete;
  logic [10:0] dp_opcode;
  logic [31:0] dp_op0, dp_op1, dp_result;
  logic        busy, err;
  logic [31:0] ops_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          k;
  } exp_t;
  exp_t sb[$];

  float_copro_ctrl #(.LAT_ADD(1), .LAT_MUL(2), .LAT_DIV(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .user_valid_i     (user_valid),
    .user_opcode_i    (user_opcode),
    .user_operand_0_i (user_op0),
    .user_operand_1_i (user_op1),
    .user_result_o    (user_result),
    .user_complete_o  (user_complete),
    .dp_opcode_o      (dp_opcode),
    .dp_op0_o         (dp_op0),
    .dp_op1_o         (dp_op1),
    .dp_result_i      (dp_result),
    .busy_o           (busy),
    .err_o            (err),
    .ops_done_o       (ops_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: 32-bit unsigned, truncated.
  always_comb begin
    dp_result = '0;
    case (dp_opcode)
      11'd0: dp_result = dp_op0 + dp_op1;
      11'd1: dp_result = dp_op0 - dp_op1;
      11'd2: dp_result = dp_op0 * dp_op1;
      11'd3: dp_result = (dp_op1 != 0) ? dp_op0 / dp_op1 : 32'd0;
      default: dp_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request, hold valid until complete, then drop it and check the count.
  task automatic run_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic eerr, input int elat,
                        input bit mutate);
    exp_t e;
    bit   seen;
    @(negedge clk);
    user_valid  = 1'b1;
    user_opcode = opc;
    user_op0    = a;
    user_op1    = b;
    e.res = eres; e.err = eerr; e.lat = elat; e.k = cyc;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (user_complete) begin
        seen = 1'b1;
        e = sb.pop_front();
        check("latency", 32'(cyc - e.k), 32'(e.lat));
        check("result",  user_result, e.res);
        check("err",     {31'd0, err}, {31'd0, e.err});
        check("busy_done", {31'd0, busy}, 32'd1);
      end else begin
        check("result_gated", user_result, 32'd0);
        check("err_gated",    {31'd0, err}, 32'd0);
      end
      if (mutate && i == 0) begin
        user_opcode = 11'd5;
        user_op0    = ~a;
        user_op1    = ~b;
      end
    end
    if (!seen) begin
      check("complete_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    user_valid = 1'b0;
    n_done++;
    check("ops_done", ops_done, 32'(n_done));
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_complete"}, {31'd0, user_complete}, 32'd0);
    check({tag, "_result"},   user_result, 32'd0);
    check({tag, "_err"},      {31'd0, err}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_ops_done"}, ops_done, 32'd0);
    check({tag, "_dp_opc"},   {21'd0, dp_opcode}, 32'd0);
    check({tag, "_dp_op0"},   dp_op0, 32'd0);
    check({tag, "_dp_op1"},   dp_op1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cmp;
    rst = 1'b1; user_valid = 1'b0; user_opcode = '0; user_op0 = '0; user_op1 = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(11'd0, 32'd5, 32'd7, 32'd12, 1'b0, 2, 1'b0);
    run_op(11'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 2, 1'b0);
    run_op(11'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 3, 1'b0);
    run_op(11'd3, 32'd100, 32'd7, 32'd14, 1'b0, 9, 1'b0);
    run_op(11'd3, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    check("div0_dp_opc", {21'd0, dp_opcode}, 32'd3);
    check("div0_dp_op0", dp_op0, 32'd100);
    check("div0_dp_op1", dp_op1, 32'd7);
    run_op(11'd5, 32'd1, 32'd2, 32'd0, 1'b1, 1, 1'b0);
    run_op(11'd4, 32'd1, 32'd2, 32'd0, 1'b1, 1, 1'b0);
    run_op(11'h7FF, 32'd1, 32'd0, 32'd0, 1'b1, 1, 1'b0);
    check("illegal_dp_opc", {21'd0, dp_opcode}, 32'd3);
    run_op(11'd2, 32'd6, 32'd7, 32'd42, 1'b0, 3, 1'b1);
    check("mutate_dp_opc", {21'd0, dp_opcode}, 32'd2);
    check("mutate_dp_op0", dp_op0, 32'd6);
    check("mutate_dp_op1", dp_op1, 32'd7);
    run_op(11'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 2, 1'b0);

    // Reset in the middle of a divide: no completion, everything cleared.
    @(negedge clk);
    user_valid = 1'b1; user_opcode = 11'd3; user_op0 = 32'd100; user_op1 = 32'd7;
    repeat (3) @(negedge clk);
    check("div_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1; user_valid = 1'b0;
    #1 check_all_zero("midrst");
    #1 rst = 1'b0;
    n_cmp = 0;
    repeat (12) begin
      @(negedge clk);
      if (user_complete) n_cmp++;
    end
    check("midrst_no_complete", 32'(n_cmp), 32'd0);
    n_done = 0;
    run_op(11'd0, 32'd1, 32'd1, 32'd2, 1'b0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
